expr_emitter: RTL

//   Transmit side of the expression character stream: serialises a packed

---
 rtl/expr_emitter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/expr_emitter.sv
// ---------------------------------------------------------------------------
// expr_emitter
//   Serialises a packed expression descriptor into a stream of 8-bit ASCII
//   characters of the form  digit (op digit)*  with op in {'+','*'}. At most
//   one parenthesised group may wrap a run of digits. The stream uses a
//   valid/ready handshake and can feed the expression recogniser directly or
//   through a FIFO.
//
// Ports
//   clk        in   1        rising-edge clock
//   clr        in   1        synchronous active-high reset (wins over start)
//   start      in   1        descriptor valid, sampled only while idle
//   cnt        in   CW       number of digits, 1..MAXN
//   digits     in   4*MAXN   digit i = digits[4i+3:4i], each 0..9
//   ops        in   MAXN-1   op i sits between digit i and digit i+1 (1='*')
//   par_en     in   1        emit one parenthesised group
//   par_lo     in   CW-1     index of first digit inside the group
//   par_hi     in   CW-1     index of last digit inside the group
//   out_valid  out  1        out_char is valid
//   out_char   out  8        ASCII character
//   out_ready  in   1        consumer accepts; transfer = out_valid & out_ready
//   busy       out  1        stream in progress (cycle after start .. done)
//   done       out  1        one-cycle pulse after the last transfer
//   err        out  1        one-cycle pulse: descriptor rejected
// ---------------------------------------------------------------------------
module expr_emitter #(
    parameter int         MAXN   = 8,
    parameter logic [7:0] ADD_CH = 8'h2B,
    parameter logic [7:0] MUL_CH = 8'h2A,
    localparam int        CW     = $clog2(MAXN) + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [CW-1:0]     cnt,
    input  logic [4*MAXN-1:0] digits,
    input  logic [MAXN-2:0]   ops,
    input  logic              par_en,
    input  logic [CW-2:0]     par_lo,
    input  logic [CW-2:0]     par_hi,
    output logic              out_valid,
    output logic [7:0]        out_char,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_DIG   = 3'd2,
        S_CLOSE = 3'd3,
        S_OP    = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    // Control state
    state_t              state_q, state_d;
    logic [CW-2:0]       i_q, i_d;
    logic                err_q, err_d;

    // Latched descriptor (no reset needed: only read outside IDLE)
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*MAXN-1:0]   digits_q, digits_d;
    logic [MAXN-1:0]     ops_q, ops_d;      // padded to MAXN so any i is in range
    logic                par_en_q, par_en_d;
    logic [CW-2:0]       lo_q, lo_d;
    logic [CW-2:0]       hi_q, hi_d;

    logic                bad_digit;
    logic                desc_ok;
    logic [3:0]          cur_dig;
    logic                more_left;
    logic [CW-2:0]       i_inc;
    logic                xfer;

    // Only digits below cnt are checked; unused digit slots may hold anything.
    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < MAXN; k++) begin
            if ((CW'(k) < cnt) && (digits[4*k +: 4] > 4'd9)) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign desc_ok = (cnt != '0) && (cnt <= CW'(MAXN)) && !bad_digit &&
                     !(par_en && ((par_lo > par_hi) || ({1'b0, par_hi} >= cnt)));

    assign cur_dig   = digits_q[{i_q, 2'b00} +: 4];
    assign more_left = ({1'b0, i_q} + CW'(1)) < cnt_q;
    assign i_inc     = i_q + (CW-1)'(1);
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        ops_d     = ops_q;
        par_en_d  = par_en_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        out_valid = 1'b0;
        out_char  = 8'h00;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (desc_ok) begin
                        cnt_d    = cnt;
                        digits_d = digits;
                        ops_d    = {1'b0, ops};
                        par_en_d = par_en;
                        lo_d     = par_lo;
                        hi_d     = par_hi;
                        i_d      = '0;
                        state_d  = (par_en && (par_lo == '0)) ? S_OPEN : S_DIG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_OPEN: begin
                out_valid = 1'b1;
                out_char  = 8'h28;
                if (xfer) state_d = S_DIG;
            end
            S_DIG: begin
                out_valid = 1'b1;
                out_char  = 8'h30 + {4'h0, cur_dig};
                if (xfer) begin
                    if (par_en_q && (i_q == hi_q)) state_d = S_CLOSE;
                    else if (more_left)            state_d = S_OP;
                    else                           state_d = S_FIN;
                end
            end
            S_CLOSE: begin
                out_valid = 1'b1;
                out_char  = 8'h29;
                if (xfer) state_d = more_left ? S_OP : S_FIN;
            end
            S_OP: begin
                out_valid = 1'b1;
                out_char  = ops_q[i_q] ? MUL_CH : ADD_CH;
                if (xfer) begin
                    i_d     = i_inc;
                    // The group opens in front of the digit that follows this op.
                    state_d = (par_en_q && (i_inc == lo_q)) ? S_OPEN : S_DIG;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q    <= cnt_d;
        digits_q <= digits_d;
        ops_q    <= ops_d;
        par_en_q <= par_en_d;
        lo_q     <= lo_d;
        hi_q     <= hi_d;
    end

    assign err = err_q;

endmodule
